// File: rtl/alu_pkg.sv
// Shared opcode map, opcode classification helpers and controller state encoding.
// The WAKE state only exists when ALU_CLK_GATE_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_SHR  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;

    // MUL/DIV finish on alu_valid; everything else has a fixed latency.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // 4'hE and 4'hF are unassigned and never reach the ALU.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hE) || (op == 4'hF);
    endfunction

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
`ifdef ALU_CLK_GATE_EN
        StWake  = 3'd1,
`endif
        StIssue = 3'd2,
        StWait  = 3'd3,
        StResp  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. On a tie the requester that did not win last
// time is granted; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_any,
    output logic gnt_id
);

    logic last_grant_q;

    // Grant decode; a grant is only issued while en is high.
    always_comb begin
        gnt_id  = (req0 && req1) ? ~last_grant_q : req1;
        gnt_any = en && (req0 || req1);
        gnt0    = gnt_any && !gnt_id;
        gnt1    = gnt_any && gnt_id;
    end

    // Remember the winner of each accepted grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else if (gnt_any) begin
            last_grant_q <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, issue a start pulse,
// wait a fixed latency (or alu_valid for MUL/DIV, bounded by TIMEOUT), then return
// the result tagged with the requester id. Define ALU_CLK_GATE_EN to gate the ALU
// clock (alu_en) whenever no operation is in flight; otherwise alu_en is tied high.
module alu_req_arbiter #(
    parameter int unsigned FIX_LAT = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_z_high,
    output logic [15:0] rsp_z_low,
    output logic        rsp_err,
    output logic        alu_en,
    output logic        alu_start,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_z_high,
    input  logic [15:0] alu_z_low,
    input  logic        alu_valid,
    output logic        busy
);

    import alu_pkg::*;

    localparam int unsigned CntMax = (TIMEOUT > FIX_LAT) ? TIMEOUT : FIX_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    ctrl_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       op_q;
    logic [15:0]      a_q, b_q;
    logic             id_q, err_q;
    logic [15:0]      zh_q, zl_q;

    logic             gnt_any, gnt_id;
    logic [3:0]       sel_op;
    logic [15:0]      sel_a, sel_b;
    logic             accept, capture, cap_err;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == StIdle),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .gnt0    (req0_ready),
        .gnt1    (req1_ready),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    assign sel_op = gnt_id ? req1_op : req0_op;
    assign sel_a  = gnt_id ? req1_a  : req0_a;
    assign sel_b  = gnt_id ? req1_b  : req0_b;

    // Next-state decode plus the start pulse and capture strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        cap_err   = 1'b0;
        alu_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    accept = 1'b1;
                    if (is_illegal(sel_op)) begin
                        state_d = StResp;
                    end else begin
`ifdef ALU_CLK_GATE_EN
                        state_d = StWake;
`else
                        state_d = StIssue;
`endif
                    end
                end
            end
`ifdef ALU_CLK_GATE_EN
            StWake: state_d = StIssue;
`endif
            StIssue: begin
                alu_start = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                if (is_multicycle(op_q)) begin
                    // A late alu_valid on the timeout cycle still wins.
                    if (alu_valid) begin
                        capture = 1'b1;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        capture = 1'b1;
                        cap_err = 1'b1;
                    end
                end else if (cnt_q == CntW'(FIX_LAT - 1)) begin
                    capture = 1'b1;
                end
                if (capture) state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= 4'h0;
            a_q   <= 16'h0;
            b_q   <= 16'h0;
            id_q  <= 1'b0;
            err_q <= 1'b0;
            zh_q  <= 16'h0;
            zl_q  <= 16'h0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                id_q <= gnt_id;
                if (is_illegal(sel_op)) begin
                    // ALU operand registers are left untouched.
                    err_q <= 1'b1;
                    zh_q  <= 16'h0;
                    zl_q  <= 16'h0;
                end else begin
                    op_q <= sel_op;
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                end
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture) begin
                err_q <= cap_err;
                zh_q  <= cap_err ? 16'h0 : alu_z_high;
                zl_q  <= cap_err ? 16'h0 : alu_z_low;
            end
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;
    assign rsp_z_high = zh_q;
    assign rsp_z_low  = zl_q;
    assign busy       = (state_q != StIdle);

`ifdef ALU_CLK_GATE_EN
    assign alu_en = (state_q == StWake) || (state_q == StIssue) || (state_q == StWait);
`else
    assign alu_en = 1'b1;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU answers start pulses, expected
// responses are queued as requests are driven and popped on each response handshake.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

    localparam int FIX_LAT = 2;
    localparam int TIMEOUT = 64;
`ifdef ALU_CLK_GATE_EN
    localparam int GATE = 1;
`else
    localparam int GATE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_z_high, rsp_z_low;
    logic        alu_en, alu_start, alu_valid;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_z_high, alu_z_low;
    logic        busy;

    typedef struct packed {
        logic        id;
        logic [15:0] zh;
        logic [15:0] zl;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    // Behavioural ALU controls.
    int   m_delay = 17;
    bit   m_hang  = 1'b0;
    bit   m_stale = 1'b0;
    int   m_cnt;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b;

    always #5 clk = ~clk;

    alu_req_arbiter #(.FIX_LAT(FIX_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z_high (rsp_z_high),
        .rsp_z_low  (rsp_z_low),
        .rsp_err    (rsp_err),
        .alu_en     (alu_en),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z_high (alu_z_high),
        .alu_z_low  (alu_z_low),
        .alu_valid  (alu_valid),
        .busy       (busy)
    );

    function automatic rsp_t mk(input logic id, input logic [15:0] zh, input logic [15:0] zl,
                                input logic err);
        rsp_t r;
        r.id = id; r.zh = zh; r.zl = zl; r.err = err;
        return r;
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            4'h0:    return {16'h0, a} + {16'h0, b};
            4'h1:    return {16'h0, a - b};
            4'h2:    return {16'h0, a} * {16'h0, b};
            4'h3:    return (b != 16'h0) ? {a % b, a / b} : 32'hFFFF_FFFF;
            default: return {16'h0, a ^ b};
        endcase
    endfunction

    // Behavioural ALU: single-pass results ready after the start edge, MUL/DIV after m_delay.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt      <= 0;
            alu_valid  <= 1'b0;
            alu_z_high <= 16'h0;
            alu_z_low  <= 16'h0;
        end else begin
            alu_valid <= 1'b0;
            if (alu_start) begin
                m_op <= alu_op;
                m_a  <= alu_a;
                m_b  <= alu_b;
                if (alu_op == 4'h2 || alu_op == 4'h3) begin
                    {alu_z_high, alu_z_low} <= 32'hDEAD_BEEF;
                    if (!m_hang) m_cnt <= m_delay;
                end else begin
                    {alu_z_high, alu_z_low} <= alu_fn(alu_op, alu_a, alu_b);
                    if (m_stale) alu_valid <= 1'b1;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    {alu_z_high, alu_z_low} <= alu_fn(m_op, m_a, m_b);
                    alu_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (alu_start) start_cnt++;

    // Scoreboard: compare each response handshake with the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d zh=%h zl=%h err=%0d, required none",
                         rsp_id, rsp_z_high, rsp_z_low, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_z_high, rsp_z_low, rsp_err} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d zh=%h zl=%h err=%0d, required id=%0d zh=%h zl=%h err=%0d",
                             rsp_id, rsp_z_high, rsp_z_low, rsp_err, e.id, e.zh, e.zl, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issue one request, wait for acceptance and then for rsp_valid. edges counts clock
    // edges from the accepting edge to the first edge that sees rsp_valid; held reports
    // whether alu_op/a/b matched the request on every cycle before the response.
    task automatic send(input bit id, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, output int edges, output bit held);
        bit ok;
        int n;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        n    = 0;
        held = 1'b1;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            if (alu_op !== op || alu_a !== a || alu_b !== b) held = 1'b0;
            @(negedge clk);
            n++;
        end
        edges = ok ? n + 1 : -1;
    endtask

    // With both valids already driven, accept both requests and report who went first.
    task automatic accept_pair(output bit ok, output bit first_id, output bit both);
        bit g0, g1, first_set, r0, r1;
        g0 = 1'b0; g1 = 1'b0; both = 1'b0; first_id = 1'b0; first_set = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (g0 && g1) break;
            @(negedge clk);
            r0 = req0_ready;
            r1 = req1_ready;
            if (r0 && r1) both = 1'b1;
            if (r0 || r1) begin
                if (!first_set) begin
                    first_id  = r1;
                    first_set = 1'b1;
                end
                @(posedge clk); #1;
                if (r0) begin req0_valid = 1'b0; g0 = 1'b1; end
                if (r1) begin req1_valid = 1'b0; g1 = 1'b1; end
            end
        end
        ok = g0 && g1;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding busy=%0d, required 0 and idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rst = 1'b0;
        #13;
        checks++;
        if ({rsp_valid, rsp_id, rsp_z_high, rsp_z_low, rsp_err, alu_start, alu_op, alu_a, alu_b,
             busy, req0_ready, req1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rsp_valid=%0d busy=%0d alu_start=%0d alu_a=%h, required all 0",
                     rsp_valid, busy, alu_start, alu_a);
        end
        checks++;
        if (alu_en !== (GATE == 0)) begin
            errors++;
            $display("FAIL reset_alu_en: got %0d, required %0d", alu_en, GATE == 0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add();
        int edges;
        bit held;
        rsp_ready = 1'b1;
        m_stale   = 1'b1;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h007D, 1'b0));
        send(1'b0, 4'h0, 16'd100, 16'd25, edges, held);
        checks++;
        if (edges != FIX_LAT + 2 + GATE) begin
            errors++;
            $display("FAIL add_latency: got %0d edges, required %0d", edges, FIX_LAT + 2 + GATE);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL add_operands: alu_op/a/b not held, required op=0 a=0064 b=0019");
        end
        wait_drain("add");
        m_stale = 1'b0;
    endtask

    task automatic test_mul();
        int edges, s0;
        bit held;
        m_delay = 17;
        s0 = start_cnt;
        exp_q.push_back(mk(1'b1, 16'h0000, 16'h4650, 1'b0));
        send(1'b1, 4'h2, 16'd150, 16'd120, edges, held);
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL mul_start_pulse: got %0d cycles high, required 1", start_cnt - s0);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL mul_operands: alu_op/a/b changed during WAIT, required op=2 a=0096 b=0078");
        end
        wait_drain("mul");
    endtask

    task automatic test_contention();
        bit ok, first, both;
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_op = 4'h0;
            req1_valid = 1'b1; req1_op = 4'h0;
            if (r == 0) begin
                req0_a = 16'd1;     req0_b = 16'd2;
                req1_a = 16'd10;    req1_b = 16'd20;
                exp_q.push_back(mk(1'b0, 16'h0000, 16'h0003, 1'b0));
                exp_q.push_back(mk(1'b1, 16'h0000, 16'h001E, 1'b0));
            end else begin
                req0_a = 16'h8000;  req0_b = 16'h8000;
                req1_a = 16'h1234;  req1_b = 16'h1111;
                exp_q.push_back(mk(1'b0, 16'h0001, 16'h0000, 1'b0));
                exp_q.push_back(mk(1'b1, 16'h0000, 16'h2345, 1'b0));
            end
            accept_pair(ok, first, both);
            checks++;
            if (!ok || both) begin
                errors++;
                $display("FAIL contention_accept: round %0d accepted_both=%0d dual_ready=%0d, required 1 and 0",
                         r, ok, both);
            end
            checks++;
            if (first !== 1'b0) begin
                errors++;
                $display("FAIL contention_order: round %0d first id %0d, required 0", r, first);
            end
        end
        wait_drain("contention");
    endtask

    task automatic test_illegal();
        int edges, s0;
        bit held;
        s0 = start_cnt;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h0000, 1'b1));
        send(1'b0, 4'hE, 16'h1234, 16'h5678, edges, held);
        checks++;
        if (edges != 1) begin
            errors++;
            $display("FAIL illegal_latency: got %0d edges, required 1", edges);
        end
        exp_q.push_back(mk(1'b1, 16'h0000, 16'h0000, 1'b1));
        send(1'b1, 4'hF, 16'hFFFF, 16'hFFFF, edges, held);
        wait_drain("illegal");
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL illegal_start: alu_start high %0d cycles, required 0", start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int edges, s0;
        bit held;
        m_hang = 1'b1;
        s0 = start_cnt;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h0000, 1'b1));
        send(1'b0, 4'h3, 16'd1000, 16'd7, edges, held);
        checks++;
        if (edges != TIMEOUT + 2 + GATE) begin
            errors++;
            $display("FAIL timeout_latency: got %0d edges, required %0d", edges, TIMEOUT + 2 + GATE);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL timeout_start: got %0d cycles high, required 1", start_cnt - s0);
        end
        wait_drain("timeout");
        m_hang = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        bit held, stable, ok, first, both;
        rsp_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h000F, 1'b0));
        send(1'b0, 4'h0, 16'd7, 16'd8, edges, held);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 4'h0; req1_a = 16'hFFFF; req1_b = 16'h0001;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'd2;    req0_b = 16'd2;
        exp_q.push_back(mk(1'b1, 16'h0001, 16'h0000, 1'b0));
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h0004, 1'b0));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_z_low !== 16'h000F ||
                rsp_z_high !== 16'h0 || rsp_err !== 1'b0 || req0_ready || req1_ready)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%0d id=%0d zl=%h ready0=%0d ready1=%0d, required 1 0 000f 0 0",
                     rsp_valid, rsp_id, rsp_z_low, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        accept_pair(ok, first, both);
        checks++;
        if (!ok || first !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_order: accepted=%0d first id %0d, required 1 and 1", ok, first);
        end
        wait_drain("backpressure");
    endtask

`ifdef ALU_CLK_GATE_EN
    task automatic test_gating();
        bit seen_wake, seq_ok;
        int n;
        rsp_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h0009, 1'b0));
        @(negedge clk);
        checks++;
        if (alu_en !== 1'b0) begin
            errors++;
            $display("FAIL gate_idle: alu_en %0d, required 0", alu_en);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'd4; req0_b = 16'd5;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        seen_wake = 1'b0; seq_ok = 1'b1; n = 0;
        @(negedge clk);
        // First busy cycle: enable without start; the next one carries the start pulse.
        if (alu_en !== 1'b1 || alu_start !== 1'b0) seq_ok = 1'b0;
        @(negedge clk);
        if (alu_en !== 1'b1 || alu_start !== 1'b1) seq_ok = 1'b0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!seq_ok || alu_en !== 1'b0 || !rsp_valid) begin
            errors++;
            $display("FAIL gate_sequence: order_ok=%0d alu_en_in_resp=%0d, required 1 and 0",
                     seq_ok, alu_en);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain("gating");
    endtask
`endif

    task automatic test_reset_mid();
        bit ok, first, both, quiet;
        rsp_ready = 1'b1;
        m_delay = 17;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'h2; req0_a = 16'd3; req0_b = 16'd4;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_z_high, rsp_z_low, rsp_err, alu_start, alu_op, alu_a, alu_b,
             busy, req0_ready, req1_ready} !== '0 || alu_en !== (GATE == 0)) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%0d alu_a=%h alu_op=%h alu_en=%0d, required 0 0000 0 %0d",
                     busy, alu_a, alu_op, alu_en, GATE == 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_mid_quiet: response or activity after release, required none");
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'd5; req0_b = 16'd5;
        req1_valid = 1'b1; req1_op = 4'h0; req1_a = 16'd6; req1_b = 16'd6;
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h000A, 1'b0));
        exp_q.push_back(mk(1'b1, 16'h0000, 16'h000C, 1'b0));
        accept_pair(ok, first, both);
        checks++;
        if (!ok || first !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: accepted=%0d first id %0d, required 1 and 0", ok, first);
        end
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_contention();
        test_illegal();
        test_timeout();
        test_backpressure();
`ifdef ALU_CLK_GATE_EN
        test_gating();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU_16bit_icg instance between two requesters.
- Accepts op/A/B requests through valid/ready handshakes, arbitrates round-robin and drives the ALU start/op/A/B.
- Waits a fixed latency or `valid`, depending on opcode, then returns Z_high/Z_low on a shared response channel tagged with the requester id.
- Optionally drives the ALU clock-gate enable so the ALU clock is gated whenever no operation is in flight.

Parameters:
- FIX_LAT, 2: cycles from the alu_start edge to sampling Z for single-pass ops (all ops except MUL 4'b0010 and DIV 4'b0011).
- TIMEOUT, 64: maximum cycles spent waiting for alu_valid on MUL/DIV before aborting with an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_op  in  4  ALU opcode.
- req0_a  in  16  operand A.
- req0_b  in  16  operand B.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_z_high  out  16  result high word.
- rsp_z_low  out  16  result low word.
- rsp_err  out  1  illegal opcode or timeout.
- alu_en  out  1  ALU clock-gate enable.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_op  out  4  opcode to the ALU.
- alu_a  out  16  operand A to the ALU.
- alu_b  out  16  operand B to the ALU.
- alu_z_high  in  16  ALU result high word.
- alu_z_low  in  16  ALU result low word.
- alu_valid  in  1  ALU MUL/DIV done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=1 (so req0 wins first).
  - All outputs 0, except alu_en=1 when ALU_CLK_GATE_EN is undefined.
  - Reset mid-operation abandons the op: no response is issued and alu_start is forced low immediately.
- States: IDLE, WAKE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the one not equal to last_grant.
  - reqN_ready is combinational, high only for the granted requester in IDLE.
  - On handshake: latch op/a/b/id, update last_grant.
  - Next state is WAKE if gating is compiled in, otherwise ISSUE.
  - If the opcode is 4'hE or 4'hF, go directly to RESP with err=1 and Z=0; the ALU is not touched.
- WAKE (gating only): alu_en=1 for one cycle, then ISSUE.
- ISSUE:
  - alu_start=1 for exactly one cycle.
  - alu_op/a/b are driven from the latched values and held stable until Z is captured.
  - Load cycle counter to 0, then go to WAIT.
- WAIT, single-pass ops: the counter increments each cycle. When it reaches FIX_LAT-1, capture alu_z_high/low and go to RESP.
- WAIT, MUL/DIV: capture on the first cycle with alu_valid=1. If the counter reaches TIMEOUT-1 first, capture Z=0 with err=1.
- WAIT, stale alu_valid: alu_valid during a single-pass op is ignored.
- RESP:
  - rsp_valid=1 with stable id/data/err until rsp_ready=1.
  - On the handshake edge, return to IDLE; no new request is accepted in that same cycle.
- Latency: with rsp_ready held high, rsp_valid rises FIX_LAT+2 cycles after the accepting edge for single-pass ops (+1 with gating). Minimum cycle per op is FIX_LAT+3.
- busy: high in every state except IDLE.
- No arithmetic in this block; results pass through bit-exact.

Optional Feature:
- ALU_CLK_GATE_EN defined:
  - alu_en=0 in IDLE and RESP.
  - alu_en=1 in WAKE/ISSUE/WAIT.
  - WAKE state present.
- ALU_CLK_GATE_EN undefined:
  - alu_en tied 1.
  - WAKE unreachable and omitted.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD 4'b0000 … OP_ROR 4'b1101), plus OP_MUL and OP_DIV.
  - is_multicycle function.
  - controller state encoding.
- One sub-module, rr_arb2: two-requester round-robin grant with last_grant register.

Test Plan:
- ADD: req0 op=0000, A=100, B=25, rsp_ready=1 → rsp_id=0, z_low=0x007D, z_high=0x0000, err=0, rsp_valid exactly FIX_LAT+2 cycles after accept.
- MUL: req1 op=0010, A=150, B=120, ALU model asserts valid after 17 cycles → rsp_id=1, z_low=0x4650, z_high=0x0000. alu_start is high exactly 1 cycle; alu_a/alu_b stable throughout WAIT.
- Contention: both requesters valid with ADD, then again → responses in order id 0, 1, 0, 1; no request lost.
- Illegal opcode and timeout:
  - req0 op=1110 → rsp_err=1, Z=0, alu_start never asserted.
  - DIV with an ALU model that never asserts valid → err=1 after TIMEOUT cycles in WAIT.
- Backpressure and reset:
  - rsp_ready=0 for 10 cycles → rsp_valid/data held; both req_ready stay 0.
  - rst low mid-WAIT → all outputs reset immediately; no response after release.
- With ALU_CLK_GATE_EN defined: alu_en=0 while idle, rises one cycle before alu_start, and falls on entry to RESP.
